node_ram_responder: RTL and testbench
=====================================

# node_ram_responder

On-chip node store that answers the engine-side memory request interface (`mem_valid`/`mem_ready`, `mem_rd`/`mem_wr`, `mem_rd_valid`/`mem_rd_ready`) directly, without going through AXI4 RAM. Used for small tree configurations and as a deterministic memory in engine simulation. It holds one node per word, returns reads after a programmable fixed latency, accepts single-cycle writes, and provides a bulk clear command for tree initialisation.

## Interface
- `RAM_DATA_WIDTH`, default 32: node word width.
- `RAM_ADDR_WIDTH`, default 16: width of the word address.
- `DEPTH`, default 256: number of words; legal range 2..2**RAM_ADDR_WIDTH.
- `RD_LATENCY`, default 2: cycles from read acceptance to `mem_rd_valid`; legal range 1..16.
- `aclk`  in  1  single clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `mem_valid`  in  1  request valid.
- `mem_ready`  out  1  request accepted when high together with `mem_valid`.
- `mem_rd`  in  1  request is a read.
- `mem_wr`  in  1  request is a write.
- `mem_addr`  in  RAM_ADDR_WIDTH  word address.
- `mem_wr_data`  in  RAM_DATA_WIDTH  write data.
- `mem_rd_valid`  out  1  read data valid.
- `mem_rd_ready`  in  1  read data consumed.
- `mem_rd_data`  out  RAM_DATA_WIDTH  read data.
- `clr_valid`  in  1  request to zero the whole store.
- `clr_ready`  out  1  clear accepted when high together with `clr_valid`.
- `clr_done`  out  1  one-cycle pulse when the clear completes.
- `mem_err`  out  1  sticky error flag.

## Operation
- States: RESP_IDLE, RESP_RD_WAIT, RESP_RD_CPL, RESP_CLEAR.
- `clr_ready` = IDLE && aresetn.
- `mem_ready` = IDLE && aresetn && !clr_valid. Clear has priority over a request in the same cycle.
- **Write** (`mem_wr`=1, accepted): the array is written at the acceptance edge. The FSM stays in IDLE, so back-to-back writes run at one per cycle.
- **Read** (`mem_rd`=1, `mem_wr`=0, accepted):
  - The array word is sampled at the acceptance edge and the latency counter is loaded with RD_LATENCY-1.
  - RESP_RD_WAIT decrements the counter. The FSM enters RESP_RD_CPL when the counter is 0, or directly if RD_LATENCY=1.
  - In RESP_RD_CPL, `mem_rd_valid`=1 and data is held stable until `mem_rd_ready`. On the handshake the FSM returns to IDLE.
- **Both bits set**: the write is performed, no read completion is produced, and `mem_err` is set.
- **Neither bit set**: the request is consumed with no effect, and `mem_err` is set.
- **Address ≥ DEPTH**: a write is dropped; a read returns all-zero data with normal timing. Both set `mem_err`.
- **Clear**: RESP_CLEAR writes zero to address counter 0..DEPTH-1, one word per cycle. After the last word the FSM returns to IDLE and `clr_done` pulses high in the first IDLE cycle. Clear start also resets `mem_err`.
- Read-after-write to the same address returns the new data.

## Timing
- Reset values: `mem_ready` 0, `clr_ready` 0, `mem_rd_valid` 0, `mem_rd_data` 0, `clr_done` 0, `mem_err` 0, FSM IDLE.
- Reset does not initialise array contents, so that the array infers RAM. A clear is required before first use.
- Read latency: acceptance at edge N gives `mem_rd_valid` high after edge N+RD_LATENCY. `mem_ready` is high in the cycle after the read handshake.
- `mem_rd_valid` never drops without `mem_rd_ready`, and `mem_rd_data` does not change while `mem_rd_valid` is high.
- Clear lasts DEPTH cycles in RESP_CLEAR. `mem_ready`/`clr_ready` are low throughout the clear.
- Reset asserted mid-read or mid-clear: all outputs go to their reset values immediately and the pending read is discarded. Array contents written before reset are retained; a clear interrupted by reset is only partially done.

## Structure
- Add to shared package `bster_h`:
  - responder state typedef `resp_states` (RESP_IDLE, RESP_RD_WAIT, RESP_RD_CPL, RESP_CLEAR);
  - width macro `RESP_FSM_WIDTH`.
- Sub-module `node_ram_array`: a synchronous single-clock RAM with one write port and one registered read port, DEPTH×RAM_DATA_WIDTH, with no reset on storage. The top level owns the FSM, latency counter, clear counter, address range check and error flag.

## Test plan
- **Clear**: DEPTH=256, pulse `clr_valid` after reset. Required: `clr_done` pulses exactly 256 cycles after acceptance; reads of addresses 0, 127 and 255 return 0; `mem_err`=0.
- **Write then read**: write 0xA5A50102 to address 3, then read address 3 with RD_LATENCY=2. Required: `mem_rd_valid` high 2 cycles after read acceptance with data 0xA5A50102.
- **Read backpressure**: hold `mem_rd_ready` low for 5 cycles. Required: valid and data stay stable and `mem_ready`=0 throughout; after the handshake, `mem_ready`=1 on the next cycle.
- **Out of range**: write 0xFFFFFFFF to address 300 (DEPTH=256), then read address 300. Required: the read returns 0 and `mem_err`=1; address 44 still reads 0.
- **Illegal command**: `mem_rd`=`mem_wr`=1 with data 0x11 to address 7. Required: address 7 reads 0x11, no `mem_rd_valid` follows the illegal request, and `mem_err`=1 until the next clear.
- **Reset mid-read**: `aresetn` low during RESP_RD_WAIT. Required: `mem_rd_valid`=0 at once; after release, `mem_ready`=1 and address 3 still reads 0xA5A50102.

Source files
------------

// File: rtl/bster_h.sv
// bster_h: shared types for the engine-side node store responder.
`ifndef RESP_FSM_WIDTH
`define RESP_FSM_WIDTH 2
`endif

package bster_h;
    typedef enum logic [`RESP_FSM_WIDTH-1:0] {
        RESP_IDLE,
        RESP_RD_WAIT,
        RESP_RD_CPL,
        RESP_CLEAR
    } resp_states;
    localparam int LAT_W = 4;
endpackage

// File: rtl/node_ram_array.sv
// node_ram_array: single-clock RAM, one write port and one registered read port, storage not reset.
module node_ram_array #(
    parameter int RAM_DATA_WIDTH = 32,
    parameter int IDX_WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic                      aclk,
    input  logic                      we,
    input  logic [IDX_WIDTH-1:0]      waddr,
    input  logic [RAM_DATA_WIDTH-1:0] wdata,
    input  logic                      re,
    input  logic [IDX_WIDTH-1:0]      raddr,
    output logic [RAM_DATA_WIDTH-1:0] rdata
);
    logic [RAM_DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge aclk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/node_ram_responder.sv
// node_ram_responder: on-chip node store answering engine memory requests with fixed read latency and bulk clear.
module node_ram_responder
    import bster_h::*;
#(
    parameter int RAM_DATA_WIDTH = 32,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int RD_LATENCY = 2
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic                      mem_rd,
    input  logic                      mem_wr,
    input  logic [RAM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [RAM_DATA_WIDTH-1:0] mem_wr_data,
    output logic                      mem_rd_valid,
    input  logic                      mem_rd_ready,
    output logic [RAM_DATA_WIDTH-1:0] mem_rd_data,
    input  logic                      clr_valid,
    output logic                      clr_ready,
    output logic                      clr_done,
    output logic                      mem_err
);
    localparam int IW = $clog2(DEPTH);

    resp_states state, state_nx;
    logic [LAT_W-1:0] lat_cnt;
    logic [IW-1:0] clr_cnt;
    logic [RAM_DATA_WIDTH-1:0] ram_rdata;
    logic rd_oor, accept, clr_start, in_range, rd_only, clr_last, clearing;

    assign clearing = state == RESP_CLEAR;
    assign clr_ready = state == RESP_IDLE && aresetn;
    assign mem_ready = clr_ready && !clr_valid;
    assign accept = mem_valid && mem_ready;
    assign clr_start = clr_valid && clr_ready;
    assign in_range = {1'b0, mem_addr} < (RAM_ADDR_WIDTH + 1)'(DEPTH);
    assign rd_only = mem_rd && !mem_wr;
    assign clr_last = clr_cnt == IW'(DEPTH - 1);
    assign mem_rd_valid = state == RESP_RD_CPL;
    // Out-of-range reads still use the aliased word for timing, but the data is masked to zero
    assign mem_rd_data = mem_rd_valid && !rd_oor ? ram_rdata : '0;

    node_ram_array #(
        .RAM_DATA_WIDTH(RAM_DATA_WIDTH),
        .IDX_WIDTH(IW),
        .DEPTH(DEPTH)
    ) u_array (
        .aclk(aclk),
        .we(clearing || (accept && mem_wr && in_range)),
        .waddr(clearing ? clr_cnt : mem_addr[IW-1:0]),
        .wdata(clearing ? '0 : mem_wr_data),
        .re(accept && rd_only),
        .raddr(mem_addr[IW-1:0]),
        .rdata(ram_rdata)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= RESP_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RESP_IDLE:    state_nx = clr_start ? RESP_CLEAR :
                                     accept && rd_only ? (RD_LATENCY == 1 ? RESP_RD_CPL : RESP_RD_WAIT) :
                                     RESP_IDLE;
            RESP_RD_WAIT: state_nx = lat_cnt == '0 ? RESP_RD_CPL : RESP_RD_WAIT;
            RESP_RD_CPL:  state_nx = mem_rd_ready ? RESP_IDLE : RESP_RD_CPL;
            RESP_CLEAR:   state_nx = clr_last ? RESP_IDLE : RESP_CLEAR;
            default:      state_nx = RESP_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lat_cnt <= '0;
            clr_cnt <= '0;
            rd_oor <= 1'b0;
            clr_done <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            lat_cnt <= accept ? LAT_W'(RD_LATENCY - 1) :
                       state == RESP_RD_WAIT && lat_cnt != '0 ? lat_cnt - LAT_W'(1) : lat_cnt;
            clr_cnt <= clr_start ? '0 : clearing ? clr_cnt + IW'(1) : clr_cnt;
            rd_oor <= accept ? !in_range : rd_oor;
            clr_done <= clearing && clr_last;
            mem_err <= clr_start ? 1'b0 :
                       accept && (!in_range || !(mem_rd ^ mem_wr)) ? 1'b1 : mem_err;
        end
    end
endmodule

// File: tb/tb_node_ram_responder.sv
// tb_node_ram_responder: scoreboard bench for the node store responder (DEPTH 256, latency 2).
module tb_node_ram_responder;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int DEPTH = 256;
    localparam int LAT = 2;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic mem_valid = 1'b0;
    logic mem_rd = 1'b0;
    logic mem_wr = 1'b0;
    logic mem_rd_ready = 1'b1;
    logic clr_valid = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wr_data = '0;
    logic mem_ready, mem_rd_valid, clr_ready, clr_done, mem_err;
    logic [DW-1:0] mem_rd_data;

    int vecs = 0;
    int errs = 0;
    logic [DW-1:0] sb[$];

    node_ram_responder #(
        .RAM_DATA_WIDTH(DW),
        .RAM_ADDR_WIDTH(AW),
        .DEPTH(DEPTH),
        .RD_LATENCY(LAT)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_rd(mem_rd),
        .mem_wr(mem_wr),
        .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_valid(mem_rd_valid),
        .mem_rd_ready(mem_rd_ready),
        .mem_rd_data(mem_rd_data),
        .clr_valid(clr_valid),
        .clr_ready(clr_ready),
        .clr_done(clr_done),
        .mem_err(mem_err)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic do_req(input logic rd, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        mem_valid = 1'b1;
        mem_rd = rd;
        mem_wr = wr;
        mem_addr = addr;
        mem_wr_data = data;
        @(posedge aclk);
        @(negedge aclk);
        mem_valid = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
    endtask

    task automatic issue_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        sb.push_back(exp);
        do_req(1'b1, 1'b0, addr, '0);
    endtask

    task automatic wait_rd(output logic [DW-1:0] d, output int lat, output logic [DW-1:0] exp);
        lat = 0;
        while (!mem_rd_valid && lat < 64) begin
            @(negedge aclk);
            lat++;
        end
        d = mem_rd_data;
        if (!mem_rd_valid) lat = -1;
        exp = sb.size() > 0 ? sb.pop_front() : 'x;
    endtask

    task automatic do_clear(output int n);
        clr_valid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        clr_valid = 1'b0;
        n = 0;
        while (!clr_done && n < 1000) begin
            @(negedge aclk);
            n++;
        end
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        vecs++;
        if ({mem_ready, clr_ready, mem_rd_valid, clr_done, mem_err} !== 5'b0) begin
            errs++;
            $display("FAIL reset_flags: got %b want 00000", {mem_ready, clr_ready, mem_rd_valid, clr_done, mem_err});
        end
        vecs++;
        if (mem_rd_data !== '0) begin
            errs++;
            $display("FAIL reset_data: got %h want 0", mem_rd_data);
        end
        aresetn = 1'b1;
        #1;
        vecs++;
        if ({mem_ready, clr_ready} !== 2'b11) begin
            errs++;
            $display("FAIL reset_release_ready: got %b want 11", {mem_ready, clr_ready});
        end
        @(negedge aclk);
    endtask

    task automatic test_clear;
        int n;
        int lat;
        logic [DW-1:0] d, exp;
        logic [AW-1:0] addrs [3] = '{16'd0, 16'd127, 16'd255};
        clr_valid = 1'b1;
        #1;
        vecs++;
        if ({clr_ready, mem_ready} !== 2'b10) begin
            errs++;
            $display("FAIL clear_priority: got clr_ready,mem_ready=%b want 10", {clr_ready, mem_ready});
        end
        @(posedge aclk);
        @(negedge aclk);
        clr_valid = 1'b0;
        n = 0;
        while (!clr_done && n < 1000) begin
            if (n == 100) begin
                vecs++;
                if ({mem_ready, clr_ready} !== 2'b00) begin
                    errs++;
                    $display("FAIL clear_busy_ready: got %b want 00", {mem_ready, clr_ready});
                end
            end
            @(negedge aclk);
            n++;
        end
        vecs++;
        if (n !== DEPTH) begin
            errs++;
            $display("FAIL clear_duration: got %0d cycles want %0d", n, DEPTH);
        end
        vecs++;
        if (mem_err !== 1'b0) begin
            errs++;
            $display("FAIL clear_err: got %b want 0", mem_err);
        end
        @(negedge aclk);
        vecs++;
        if (clr_done !== 1'b0) begin
            errs++;
            $display("FAIL clear_done_pulse: got %b want 0 one cycle later", clr_done);
        end
        for (int i = 0; i < 3; i++) begin
            issue_read(addrs[i], '0);
            wait_rd(d, lat, exp);
            vecs++;
            if (lat !== LAT || d !== exp) begin
                errs++;
                $display("FAIL clear_read_%0d: got data %h lat %0d want %h lat %0d", addrs[i], d, lat, exp, LAT);
            end
            @(negedge aclk);
        end
    endtask

    task automatic test_write_read;
        int lat;
        logic [DW-1:0] d, exp;
        do_req(1'b0, 1'b1, 16'd3, 32'hA5A50102);
        issue_read(16'd3, 32'hA5A50102);
        wait_rd(d, lat, exp);
        vecs++;
        if (lat !== LAT || d !== exp) begin
            errs++;
            $display("FAIL write_read: got data %h lat %0d want %h lat %0d", d, lat, exp, LAT);
        end
        @(negedge aclk);
    endtask

    task automatic test_backpressure;
        int lat;
        logic [DW-1:0] d, exp;
        do_req(1'b0, 1'b1, 16'd9, 32'hDEADBEEF);
        mem_rd_ready = 1'b0;
        issue_read(16'd9, 32'hDEADBEEF);
        wait_rd(d, lat, exp);
        vecs++;
        if (lat !== LAT || d !== exp) begin
            errs++;
            $display("FAIL bp_first: got data %h lat %0d want %h lat %0d", d, lat, exp, LAT);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            vecs++;
            if (mem_rd_valid !== 1'b1 || mem_rd_data !== exp || mem_ready !== 1'b0) begin
                errs++;
                $display("FAIL bp_hold_%0d: got valid %b data %h ready %b want 1 %h 0", i, mem_rd_valid, mem_rd_data, mem_ready, exp);
            end
        end
        mem_rd_ready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        vecs++;
        if (mem_ready !== 1'b1 || mem_rd_valid !== 1'b0) begin
            errs++;
            $display("FAIL bp_release: got ready %b valid %b want 1 0", mem_ready, mem_rd_valid);
        end
    endtask

    task automatic test_reset_mid_read;
        int lat;
        logic seen;
        logic [DW-1:0] d, exp;
        issue_read(16'd3, 32'hA5A50102);
        void'(sb.pop_back());
        aresetn = 1'b0;
        #1;
        vecs++;
        if (mem_rd_valid !== 1'b0 || mem_ready !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid_read: got valid %b ready %b want 0 0", mem_rd_valid, mem_ready);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge aclk);
            seen |= mem_rd_valid;
        end
        vecs++;
        if (seen !== 1'b0 || mem_ready !== 1'b1) begin
            errs++;
            $display("FAIL rst_discard: got stray valid %b ready %b want 0 1", seen, mem_ready);
        end
        issue_read(16'd3, 32'hA5A50102);
        wait_rd(d, lat, exp);
        vecs++;
        if (lat !== LAT || d !== exp) begin
            errs++;
            $display("FAIL rst_retained: got data %h lat %0d want %h lat %0d", d, lat, exp, LAT);
        end
        @(negedge aclk);
    endtask

    task automatic test_out_of_range;
        int lat;
        logic [DW-1:0] d, exp;
        vecs++;
        if (mem_err !== 1'b0) begin
            errs++;
            $display("FAIL oor_err_before: got %b want 0", mem_err);
        end
        do_req(1'b0, 1'b1, 16'd300, 32'hFFFFFFFF);
        vecs++;
        if (mem_err !== 1'b1) begin
            errs++;
            $display("FAIL oor_err_set: got %b want 1", mem_err);
        end
        issue_read(16'd300, '0);
        wait_rd(d, lat, exp);
        vecs++;
        if (lat !== LAT || d !== exp) begin
            errs++;
            $display("FAIL oor_read: got data %h lat %0d want %h lat %0d", d, lat, exp, LAT);
        end
        @(negedge aclk);
        issue_read(16'd44, '0);
        wait_rd(d, lat, exp);
        vecs++;
        if (lat !== LAT || d !== exp || mem_err !== 1'b1) begin
            errs++;
            $display("FAIL oor_alias: got data %h lat %0d err %b want %h lat %0d err 1", d, lat, mem_err, exp, LAT);
        end
        @(negedge aclk);
    endtask

    task automatic test_illegal;
        int n, lat;
        logic seen;
        logic [DW-1:0] d, exp;
        do_clear(n);
        @(negedge aclk);
        vecs++;
        if (mem_err !== 1'b0) begin
            errs++;
            $display("FAIL ill_clear_resets_err: got %b want 0", mem_err);
        end
        do_req(1'b1, 1'b1, 16'd7, 32'h11);
        seen = 1'b0;
        repeat (8) begin
            seen |= mem_rd_valid;
            @(negedge aclk);
        end
        vecs++;
        if (seen !== 1'b0 || mem_err !== 1'b1) begin
            errs++;
            $display("FAIL ill_both: got valid seen %b err %b want 0 1", seen, mem_err);
        end
        issue_read(16'd7, 32'h11);
        wait_rd(d, lat, exp);
        vecs++;
        if (lat !== LAT || d !== exp || mem_err !== 1'b1) begin
            errs++;
            $display("FAIL ill_write_kept: got data %h lat %0d err %b want %h lat %0d err 1", d, lat, mem_err, exp, LAT);
        end
        @(negedge aclk);
        do_clear(n);
        @(negedge aclk);
        do_req(1'b0, 1'b0, 16'd5, 32'h0);
        vecs++;
        if (mem_err !== 1'b1 || mem_ready !== 1'b1) begin
            errs++;
            $display("FAIL ill_neither: got err %b ready %b want 1 1", mem_err, mem_ready);
        end
        do_clear(n);
        @(negedge aclk);
        vecs++;
        if (mem_err !== 1'b0) begin
            errs++;
            $display("FAIL ill_err_cleared: got %b want 0", mem_err);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [DW-1:0] d, exp;
        for (int i = 0; i < 8; i++) begin
            vecs++;
            if (mem_ready !== 1'b1) begin
                errs++;
                $display("FAIL b2b_ready_%0d: got %b want 1", i, mem_ready);
            end
            do_req(1'b0, 1'b1, AW'(20 + i), 32'h10000000 + DW'(i) * 32'h01010101);
        end
        for (int i = 0; i < 8; i++) begin
            issue_read(AW'(20 + i), 32'h10000000 + DW'(i) * 32'h01010101);
            wait_rd(d, lat, exp);
            vecs++;
            if (lat !== LAT || d !== exp) begin
                errs++;
                $display("FAIL b2b_read_%0d: got data %h lat %0d want %h lat %0d", i, d, lat, exp, LAT);
            end
            @(negedge aclk);
        end
        do_req(1'b0, 1'b1, 16'd50, 32'hCAFE0050);
        issue_read(16'd50, 32'hCAFE0050);
        wait_rd(d, lat, exp);
        vecs++;
        if (lat !== LAT || d !== exp) begin
            errs++;
            $display("FAIL raw_next_cycle: got data %h lat %0d want %h lat %0d", d, lat, exp, LAT);
        end
        @(negedge aclk);
    endtask

    initial begin
        @(negedge aclk);
        test_reset();
        test_clear();
        test_write_read();
        test_backpressure();
        test_reset_mid_read();
        test_out_of_range();
        test_illegal();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
